// File: rtl/irq_pkg.sv
// Shared types for the priority interrupt controller.
// Default widths match a 16-source, 3-bit-priority build.
package irq_pkg;

   localparam int DEF_NUM_SRC = 16;
   localparam int DEF_PRIO_W  = 3;
   localparam int DEF_ID_W    = $clog2(DEF_NUM_SRC);

   // Priority value that can never raise an interrupt
   localparam int PRIO_NEVER  = 0;

   typedef logic [DEF_PRIO_W-1:0] prio_t;
   typedef logic [DEF_ID_W-1:0]   id_t;

   typedef struct packed {
      logic hit;
      id_t  id;
   } claim_resp_t;

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: edge/level capture into a one-deep pending bit.
// In edge mode a new edge beats a same-cycle claim clear.
module irq_gateway
   import irq_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic irq,
   input  logic edge_mode,
   input  logic set_block,
   input  logic claim_clr,
   output logic pending
);

   logic prev;
   logic set_d;

   // Set condition: rising edge, or level while not held in service
   always_comb begin
      if (edge_mode) begin
         set_d = irq & ~prev;
      end else begin
         set_d = irq & ~set_block & ~claim_clr;
      end
   end

   // Pending bit and previous sample for edge detection
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev    <= 1'b0;
         pending <= 1'b0;
      end else begin
         prev <= irq;
         if (set_d) begin
            pending <= 1'b1;
         end else if (claim_clr) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/priority_irq_controller.sv
// Priority interrupt controller with threshold, round-robin ties
// and a claim/complete handshake.
module priority_irq_controller
   import irq_pkg::*;
#(
   parameter int NUM_SRC = 16,
   parameter int PRIO_W  = 3,
   parameter int ID_W    = $clog2(NUM_SRC)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_SRC-1:0]        src_irq,
   input  logic [NUM_SRC-1:0]        src_enable,
   input  logic [NUM_SRC-1:0]        src_edge,
   input  logic [NUM_SRC*PRIO_W-1:0] src_priority,
   input  logic [PRIO_W-1:0]         threshold,
   input  logic                      claim_req,
   output logic                      claim_resp_valid,
   output logic                      claim_hit,
   output logic [ID_W-1:0]           claim_id,
   input  logic                      complete_valid,
   input  logic [ID_W-1:0]           complete_id,
   output logic                      irq_out,
   output logic [NUM_SRC-1:0]        pending,
   output logic [NUM_SRC-1:0]        in_service
);

   logic [PRIO_W-1:0]  prio [NUM_SRC];
   logic [NUM_SRC-1:0] pend;
   logic [NUM_SRC-1:0] elig;
   logic [NUM_SRC-1:0] tied;
   logic [NUM_SRC-1:0] claim_oh;
   logic [NUM_SRC-1:0] cmp_oh;
   logic [PRIO_W-1:0]  max_prio;

   logic               best_valid;
   logic [ID_W-1:0]    best_id;
   logic               best_valid_d;
   logic [ID_W-1:0]    best_id_d;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    rr_next;
   logic               claim_fire;

   logic               resp_valid_q;
   logic               resp_hit_q;
   logic [ID_W-1:0]    resp_id_q;

   assign claim_fire = claim_req & best_valid;
   assign rr_next    = claim_fire ? best_id : rr_ptr;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      assign prio[g]     = src_priority[g*PRIO_W +: PRIO_W];
      assign claim_oh[g] = claim_fire && (best_id == ID_W'(g));
      assign cmp_oh[g]   = complete_valid && in_service[g]
                           && (complete_id == ID_W'(g));

      irq_gateway u_gw (
         .clock     (clock),
         .reset     (reset),
         .irq       (src_irq[g]),
         .edge_mode (src_edge[g]),
         .set_block (in_service[g]),
         .claim_clr (claim_oh[g]),
         .pending   (pend[g])
      );
   end

   // Eligibility; a source being claimed this cycle is masked out
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         elig[i] = pend[i] && src_enable[i] && !in_service[i]
                   && !claim_oh[i] && (prio[i] > threshold)
                   && (prio[i] != PRIO_W'(PRIO_NEVER));
      end
   end

   // Highest eligible priority and the set of sources tied at it
   always_comb begin
      max_prio = '0;
      tied     = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (elig[i] && prio[i] > max_prio) max_prio = prio[i];
      end
      for (int i = 0; i < NUM_SRC; i++) begin
         tied[i] = elig[i] && (prio[i] == max_prio);
      end
   end

   // Round-robin pick: first tied index strictly after the pointer
   always_comb begin
      int idx;
      best_valid_d = 1'b0;
      best_id_d    = '0;
      idx          = 0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         idx = int'(rr_next) + k;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         if (!best_valid_d && tied[idx[ID_W-1:0]]) begin
            best_valid_d = 1'b1;
            best_id_d    = idx[ID_W-1:0];
         end
      end
   end

   // Arbiter result, pointer and in-service tracking
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         best_valid <= 1'b0;
         best_id    <= '0;
         rr_ptr     <= ID_W'(NUM_SRC - 1);
         in_service <= '0;
      end else begin
         best_valid <= best_valid_d;
         best_id    <= best_id_d;
         rr_ptr     <= rr_next;
         in_service <= (in_service & ~cmp_oh) | claim_oh;
      end
   end

   // Claim response, one cycle after each request
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_id_q    <= '0;
      end else begin
         resp_valid_q <= claim_req;
         resp_hit_q   <= claim_req & best_valid;
         resp_id_q    <= claim_fire ? best_id : '0;
      end
   end

   assign irq_out          = best_valid;
   assign pending          = pend;
   assign claim_resp_valid = resp_valid_q;
   assign claim_hit        = resp_hit_q;
   assign claim_id         = resp_id_q;

endmodule

// File: doc/priority_irq_controller.md
# priority_irq_controller

Parametrised interrupt controller for the Sensors_and_Security subsystem. It supports N sources with a programmable priority per source, a global priority threshold, and round-robin tie-breaking among equal priorities. Software takes interrupts through a claim/complete handshake, and a claimed source is held in-service until completion. It sits between the sensor/security event sources and the host CPU interrupt line.

## Interface
- NUM_SRC, 16, number of interrupt sources (2..64)
- PRIO_W, 3, priority field width; priority 0 means never interrupt
- ID_W, $clog2(NUM_SRC), source ID width
- clock  input  1  clock; all logic on posedge
- reset  input  1  reset, asynchronous, active-high
- src_irq  input  NUM_SRC  raw interrupt sources, synchronous to clock
- src_enable  input  NUM_SRC  per-source enable
- src_edge  input  NUM_SRC  1 = rising-edge, 0 = level
- src_priority  input  NUM_SRC*PRIO_W  packed priorities; source i at [i*PRIO_W +: PRIO_W]
- threshold  input  PRIO_W  only priorities strictly greater than this are eligible
- claim_req  input  1  one-cycle claim strobe
- claim_resp_valid  output  1  one-cycle pulse, exactly one cycle after each claim_req
- claim_hit  output  1  qualifies claim_resp_valid: 1 = source granted, 0 = nothing eligible
- claim_id  output  ID_W  granted source ID; 0 when claim_hit = 0
- complete_valid  input  1  completion strobe
- complete_id  input  ID_W  source being completed
- irq_out  output  1  registered: an eligible source exists
- pending  output  NUM_SRC  pending bits
- in_service  output  NUM_SRC  claimed-but-not-completed bits

## Operation
- **Gateway, per source.**
  - Edge mode: prev-sample register; rising edge sets pending[i].
  - Level mode: pending[i] is set while src_irq[i] is high and in_service[i] is 0.
  - Pending is never cleared by a level source falling; only a claim clears it.
- **Eligibility.** eligible[i] = pending & src_enable & ~in_service & (prio > threshold) & (prio != 0). A disabled source keeps its pending bit and becomes eligible on re-enable.
- **Arbitration.**
  - The highest priority among eligible sources wins.
  - Ties go round-robin: the first tied index strictly after rr_ptr, wrapping at NUM_SRC-1 back to 0.
  - rr_ptr is updated to the granted ID on each successful claim.
  - The result is registered into best_id/best_valid every cycle; irq_out = best_valid.
- **Claim.**
  - claim_req sampled high with best_valid = 1: at that edge, pending[best_id] is cleared, in_service[best_id] is set, and rr_ptr is set to best_id.
  - The response the next cycle is claim_hit = 1, claim_id = best_id.
  - The claimed ID is excluded from the arbiter in that same cycle, so best_id/irq_out never present it again.
  - With best_valid = 0: the response is claim_hit = 0, claim_id = 0, and no state changes.
- **Complete.** complete_valid with complete_id clears in_service[complete_id]. It is ignored if that bit is 0 or complete_id >= NUM_SRC.
- **Simultaneous events.**
  - Edge source: a rising edge in the claim cycle of the same source wins over the clear; pending stays 1, so the edge is not lost. Pending is only one deep, so further edges merge.
  - Level source: re-pends after complete if still high.
  - Claim and complete of different IDs in the same cycle: both take effect.
  - claim_req while claim_resp_valid is high is legal; each request is served by its own edge.
- **Reset**, at any time: pending, in_service, prev samples, best_valid, irq_out, claim_resp_valid, claim_hit and claim_id go to 0; rr_ptr goes to NUM_SRC-1, so index 0 wins the first tie. An outstanding claim response is dropped.

## Timing
- Source-to-irq_out latency: src_irq is sampled high at edge t, pending is set at t, best_valid/irq_out are high after edge t+1. Two cycles from assertion.
- Claim response is one cycle: claim_req at edge k gives claim_resp_valid during k..k+1.
- Priority and threshold changes reach irq_out one cycle after they are sampled.
- Complete to re-arbitration (level source still high): in_service clears at edge c, pending sets at c+1, irq_out at c+2.
- No combinational path from any input to any output.

## Structure
- Shared package irq_pkg holds:
  - prio_t and id_t typedefs, parameterised via package-level defaults;
  - the PRIO_NEVER = 0 constant;
  - a claim response struct {hit, id}.
- Sub-module irq_gateway: one instance per source via generate. It holds the edge/level logic, the pending bit and the prev sample, and takes set-block and claim-clear inputs.
- Top level holds the arbiter (priority max-reduction plus rotated round-robin pick), the in_service vector, rr_ptr and the claim/complete logic.

## Test plan
- Level source 3, prio 5, threshold 2, asserted at cycle 10: irq_out high at cycle 12; claim returns hit = 1, id = 3; irq_out low the next cycle; after complete with src still high, irq_out returns 2 cycles later.
- Sources 2 and 6 both prio 4, asserted together: claims return 2, then 6, then 2 again after both complete and re-pend (round-robin rotation).
- Source 1 prio 7 and source 5 prio 3 pending: claim returns 1. With threshold 3, source 5 alone never raises irq_out and a claim returns hit = 0, id = 0.
- Edge source 4: rising edge coincident with its own claim; pending[4] stays 1 and the source is claimable again right after complete.
- Source with priority 0, or disabled, asserted: irq_out stays 0. Enabling it later raises irq_out one cycle after the enable is sampled.
- Reset asserted mid-claim, between claim_req and the response: all outputs 0 next cycle; no claim_resp_valid pulse afterwards; rr_ptr restarts so that index 0 wins the first tie.
